// File: rtl/ranging_pkg.sv
// ============================================================================
//  ranging_pkg : shared types and 50 MHz timing defaults for ultrasonic ranging
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package ranging_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    WAIT_FALL = 3'd3,
    HOLDOFF   = 3'd4
  } state_e;

  localparam int unsigned DEF_TRIG_CYCLES    = 500;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1_500_000;
  localparam int unsigned DEF_PERIOD_CYCLES  = 3_000_000;
  localparam int unsigned DEF_CNT_W          = 22;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
//  sync_edge : 2-flop synchroniser with registered-delay rise/fall detection
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~dly_q;
  assign fall_o = ~sync_q & dly_q;

endmodule

`default_nettype wire

// File: rtl/ultrasonic_trigger.sv
// ============================================================================
//  ultrasonic_trigger : periodic trigger pulse, gated echo and done/timeout
//  Revision           : 1.0
// ============================================================================
`default_nettype none

module ultrasonic_trigger
  import ranging_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic echo_in,
  output logic trig_out,
  output logic echo_gated,
  output logic done,
  output logic timeout,
  output logic busy
);

  localparam logic [CNT_W-1:0] c_TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_ONE          = CNT_W'(1);

  if (TRIG_CYCLES < 1) begin : g_bad_trig
    $error("TRIG_CYCLES must be at least 1");
  end
  if (PERIOD_CYCLES <= TRIG_CYCLES + TIMEOUT_CYCLES + 4) begin : g_bad_period
    $error("PERIOD_CYCLES too short for trigger plus listen window");
  end
  if (((PERIOD_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("CNT_W cannot hold PERIOD_CYCLES-1");
  end

  logic w_echo_s;
  logic w_echo_rise;
  logic w_echo_fall;

  sync_edge u_echo_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (echo_in),
    .q_o    (w_echo_s),
    .rise_o (w_echo_rise),
    .fall_o (w_echo_fall)
  );

  state_e           state_q;
  logic [CNT_W-1:0] period_cnt_q;
  logic [CNT_W-1:0] timeout_cnt_q;
  logic             trig_q;
  logic             gated_q;
  logic             done_q;
  logic             timeout_q;
  logic             busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      period_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      trig_q        <= 1'b0;
      gated_q       <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      // Gate uses the current state, so the echo is cut the cycle after leaving the window
      gated_q   <= ((state_q == WAIT_RISE) || (state_q == WAIT_FALL)) && w_echo_s;

      if (state_q != IDLE) begin
        period_cnt_q <= period_cnt_q + c_ONE;
      end

      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q      <= TRIG;
            trig_q       <= 1'b1;
            busy_q       <= 1'b1;
            period_cnt_q <= '0;
          end
        end
        TRIG: begin
          if (period_cnt_q == c_TRIG_LAST) begin
            state_q       <= WAIT_RISE;
            trig_q        <= 1'b0;
            timeout_cnt_q <= '0;
          end
        end
        WAIT_RISE: begin
          timeout_cnt_q <= timeout_cnt_q + c_ONE;
          if (timeout_cnt_q == c_TIMEOUT_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= HOLDOFF;
          end else if (w_echo_rise) begin
            state_q <= WAIT_FALL;
          end
        end
        WAIT_FALL: begin
          timeout_cnt_q <= timeout_cnt_q + c_ONE;
          // A fall on the expiry cycle still counts as a completed measurement
          if (w_echo_fall) begin
            done_q  <= 1'b1;
            state_q <= HOLDOFF;
          end else if (timeout_cnt_q == c_TIMEOUT_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (period_cnt_q == c_PERIOD_LAST) begin
            if (enable) begin
              state_q      <= TRIG;
              trig_q       <= 1'b1;
              period_cnt_q <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          trig_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign trig_out   = trig_q;
  assign echo_gated = gated_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ultrasonic_trigger.sv
// ============================================================================
//  tb_ultrasonic_trigger : event scoreboard bench for ultrasonic_trigger
//  Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_ultrasonic_trigger;

  localparam int EV_TR = 0;
  localparam int EV_TF = 1;
  localparam int EV_GR = 2;
  localparam int EV_GF = 3;
  localparam int EV_DN = 4;
  localparam int EV_TO = 5;
  localparam int EV_BR = 6;
  localparam int EV_BF = 7;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic echo_in;
  logic trig_out;
  logic echo_gated;
  logic done;
  logic timeout;
  logic busy;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  string ev_name[8] = '{"trig_rise", "trig_fall", "gate_rise", "gate_fall",
                        "done", "timeout", "busy_rise", "busy_fall"};

  ultrasonic_trigger #(
    .TRIG_CYCLES    (4),
    .TIMEOUT_CYCLES (50),
    .PERIOD_CYCLES  (100),
    .CNT_W          (22)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .echo_in    (echo_in),
    .trig_out   (trig_out),
    .echo_gated (echo_gated),
    .done       (done),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void expect_ev(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    sb_q.push_back(e);
  endfunction

  function automatic void observe(input int kind);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL unexpected_event: got %s@%0d expected none", ev_name[kind], cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.kind == kind && e.cyc == cyc) n_pass++;
      else $display("FAIL event: got %s@%0d expected %s@%0d",
                    ev_name[kind], cyc, ev_name[e.kind], e.cyc);
    end
  endfunction

  // Monitor: turn output transitions and pulses into events, sampled mid-cycle
  logic p_trig = 1'b0, p_gate = 1'b0, p_busy = 1'b0;
  always @(negedge clk) begin
    if (trig_out && !p_trig)   observe(EV_TR);
    if (!trig_out && p_trig)   observe(EV_TF);
    if (echo_gated && !p_gate) observe(EV_GR);
    if (!echo_gated && p_gate) observe(EV_GF);
    if (done)                  observe(EV_DN);
    if (timeout)               observe(EV_TO);
    if (busy && !p_busy)       observe(EV_BR);
    if (!busy && p_busy)       observe(EV_BF);
    p_trig = trig_out;
    p_gate = echo_gated;
    p_busy = busy;
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_trig"}, int'(trig_out), 0);
    check({tag, "_gated"}, int'(echo_gated), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int t1, t2, t3, t4, t5, t6;
    reset   = 1'b0;
    enable  = 1'b0;
    echo_in = 1'b0;
    wait_cyc(2);
    check_all_low("reset");

    // Normal echo measurement
    wait_cyc(3);
    reset  = 1'b1;
    enable = 1'b1;
    t1 = cyc + 1;
    expect_ev(EV_TR, t1);
    expect_ev(EV_BR, t1);
    expect_ev(EV_TF, t1 + 4);
    expect_ev(EV_GR, t1 + 17);
    wait_cyc(t1 + 2);
    check("busy_in_trig", int'(busy), 1);
    wait_cyc(t1 + 14);
    echo_in = 1'b1;
    expect_ev(EV_GF, t1 + 37);
    expect_ev(EV_DN, t1 + 37);
    expect_ev(EV_TR, t1 + 100);
    wait_cyc(t1 + 34);
    echo_in = 1'b0;

    // No echo: timeout, period kept
    t2 = t1 + 100;
    t3 = t2 + 100;
    expect_ev(EV_TF, t2 + 4);
    expect_ev(EV_TO, t2 + 54);
    expect_ev(EV_TR, t3);

    // Echo stuck high across the trigger: no rise, timeout, gate cut afterwards
    wait_cyc(t2 + 56);
    echo_in = 1'b1;
    t4 = t3 + 100;
    expect_ev(EV_TF, t3 + 4);
    expect_ev(EV_GR, t3 + 5);
    expect_ev(EV_TO, t3 + 54);
    expect_ev(EV_GF, t3 + 55);
    expect_ev(EV_TR, t4);
    wait_cyc(t3 + 60);
    echo_in = 1'b0;

    // Enable dropped during WAIT_FALL: completes, then idles
    expect_ev(EV_TF, t4 + 4);
    expect_ev(EV_GR, t4 + 17);
    expect_ev(EV_GF, t4 + 37);
    expect_ev(EV_DN, t4 + 37);
    expect_ev(EV_BF, t4 + 100);
    wait_cyc(t4 + 14);
    echo_in = 1'b1;
    wait_cyc(t4 + 24);
    enable = 1'b0;
    wait_cyc(t4 + 34);
    echo_in = 1'b0;
    wait_cyc(t4 + 130);

    // Reset during WAIT_FALL with echo high
    enable = 1'b1;
    t5 = cyc + 1;
    expect_ev(EV_TR, t5);
    expect_ev(EV_BR, t5);
    expect_ev(EV_TF, t5 + 4);
    expect_ev(EV_GR, t5 + 17);
    wait_cyc(t5 + 14);
    echo_in = 1'b1;
    wait_cyc(t5 + 24);
    expect_ev(EV_GF, t5 + 24);
    expect_ev(EV_BF, t5 + 24);
    reset = 1'b0;
    #1;
    check_all_low("async_reset");
    wait_cyc(t5 + 27);
    reset   = 1'b1;
    echo_in = 1'b0;
    t6 = t5 + 28;
    expect_ev(EV_TR, t6);
    expect_ev(EV_BR, t6);
    expect_ev(EV_TF, t6 + 4);
    expect_ev(EV_TO, t6 + 54);
    wait_cyc(t6 + 60);

    check("pending_events", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ultrasonic_trigger.md
Name: ultrasonic_trigger

Overview:
Upstream ranging controller for the echo pulse-width measurement stage. Periodically fires a fixed-width trigger pulse to an HC-SR04-style ultrasonic sensor and synchronises the raw echo input. It opens a listen window, forwards a clean gated echo to the downstream pulse-width measurer, and flags completed measurements and timeouts.

Parameters:
TRIG_CYCLES, 500, trigger pulse width in clk cycles (10 us at 50 MHz); must be >= 1
TIMEOUT_CYCLES, 1_500_000, maximum listen window measured from WAIT_RISE entry (30 ms)
PERIOD_CYCLES, 3_000_000, trigger-start to trigger-start spacing (60 ms); must be > TRIG_CYCLES + TIMEOUT_CYCLES + 4 (elaboration-time assertion)
CNT_W, 22, width of the internal period and timeout counters; must hold PERIOD_CYCLES-1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  run request; sampled only in IDLE and at HOLDOFF expiry
echo_in  input  1  raw asynchronous echo from sensor
trig_out  output  1  registered trigger pulse to sensor
echo_gated  output  1  registered, synchronised echo; 0 outside listen window; feeds pulse-width stage
done  output  1  one-cycle pulse: echo falling edge seen inside window
timeout  output  1  one-cycle pulse: listen window expired without a completed echo
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, all outputs 0, counters 0, sync flops 0.
- echo_in passes through a 2-flop synchroniser (echo_s). Rise/fall are detected against a 1-cycle-delayed copy of echo_s.
- echo_gated is registered. It equals echo_s while state is WAIT_RISE or WAIT_FALL, else 0. Latency from echo_in to echo_gated is 3 cycles.
- States: IDLE, TRIG, WAIT_RISE, WAIT_FALL, HOLDOFF.
- IDLE: if enable=1, go to TRIG next cycle and clear period_cnt.
- TRIG:
  - trig_out=1 for exactly TRIG_CYCLES consecutive cycles.
  - Then go to WAIT_RISE and clear timeout_cnt.
  - period_cnt increments every cycle from TRIG entry, through all non-IDLE states.
- WAIT_RISE:
  - Rising edge of echo_s: go to WAIT_FALL.
  - Echo already high on entry is not a rise; a stuck-high echo therefore times out.
- WAIT_FALL: falling edge of echo_s: assert done for 1 cycle, go to HOLDOFF.
- Timeout (WAIT_RISE or WAIT_FALL):
  - timeout_cnt increments each cycle in both states.
  - At timeout_cnt == TIMEOUT_CYCLES-1 with no falling edge that cycle: assert timeout for 1 cycle, go to HOLDOFF.
  - echo_gated is forced 0 from the next cycle, so downstream sees a falling edge.
  - If the falling edge and the expiry fall on the same cycle, done wins; timeout is not asserted.
- HOLDOFF: wait until period_cnt == PERIOD_CYCLES-1. Then go to TRIG if enable=1 (period_cnt cleared), else IDLE.
- enable deassertion mid-measurement does not abort; the current cycle completes.
- done and timeout are mutually exclusive and never both high.
- trig_out is never high outside TRIG.
- Reset mid-operation: immediate return to IDLE. trig_out drops asynchronously; no done/timeout pulse.
- Counters saturate-free by construction; widths are checked by assertion.

Decomposition:
- Shared package ranging_pkg holds:
  - state enum typedef (IDLE, TRIG, WAIT_RISE, WAIT_FALL, HOLDOFF)
  - default timing constants (TRIG_CYCLES, TIMEOUT_CYCLES, PERIOD_CYCLES at 50 MHz)
- One sub-module is natural: sync_edge (2-flop synchroniser plus rise/fall pulse outputs), reusable for other asynchronous sensor inputs.

Test Plan:
Use TRIG_CYCLES=4, TIMEOUT_CYCLES=50, PERIOD_CYCLES=100.
1. Reset released, enable=1 -> trig_out high for exactly 4 cycles starting 1 cycle after enable is seen; busy=1.
2. echo_in high 20 cycles, starting 10 cycles after trig falls -> echo_gated high 20 cycles (3-cycle lag); done pulses once; next trig rises exactly 100 cycles after the previous trig rise.
3. No echo -> timeout pulses at cycle 50 of the window; done stays 0; echo_gated stays 0; next trig still at the 100-cycle spacing.
4. echo_in held high through the whole TRIG phase -> no rise is detected; timeout asserted; echo_gated returns to 0 after timeout.
5. enable dropped during WAIT_FALL -> measurement completes with done; then IDLE, busy=0, no further trig.
6. reset asserted during WAIT_FALL with echo high -> trig_out, echo_gated, done, and timeout all 0 immediately; state IDLE; after release with enable=1, a new trig of 4 cycles follows.
